// File: rtl/rtc_bus_seq.sv
// Multiplexed-bus RTC sequencer: command cycle plus NREG-register read burst, and single writes.
// All bus strobes and status outputs are registered and change on the edge entering each state.
`timescale 1ns/1ps
module rtc_bus_seq #(
    parameter int unsigned          DW        = 8,
    parameter int unsigned          NREG      = 10,
    parameter logic [NREG*DW-1:0]   ADDR_LIST = {8'h26, 8'h25, 8'h24, 8'h23, 8'h22,
                                                 8'h21, 8'h43, 8'h42, 8'h41, 8'h01},
    parameter bit                   CMD_EN    = 1'b1,
    parameter logic [DW-1:0]        CMD_ADDR  = 8'hF0,
    parameter int unsigned          T_STB     = 5,
    parameter int unsigned          T_TURN    = 8,
    parameter int unsigned          T_GAP     = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 wr_req,
    input  logic [DW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic [DW-1:0]        ad_in,
    output logic [DW-1:0]        ad_out,
    output logic                 ad_oe,
    output logic                 ad,
    output logic                 cs,
    output logic                 wr,
    output logic                 rd,
    output logic [NREG*DW-1:0]   rd_data,
    output logic                 rd_valid,
    output logic [3:0]           rd_idx,
    output logic                 burst_done,
    output logic                 wr_ack,
    output logic                 busy
);

    localparam int unsigned CW       = 16;
    localparam logic [3:0]  LAST_IDX = 4'(NREG - 1);

    typedef enum logic [3:0] {
        StIdle, StAd, StCsa, StWra, StHa, StCsah, StAdh,
        StTurn, StCsd, StStb, StHd, StCsdh, StGap
    } state_e;

    typedef enum logic [1:0] {OpCmd, OpRead, OpWrite} op_e;

    state_e              state_q;
    op_e                 op_q;
    logic [CW-1:0]       cnt_q;
    logic [3:0]          idx_q;
    logic                start_q;
    logic                pend_q;
    logic [DW-1:0]       waddr_q;
    logic [DW-1:0]       wdata_q;
    logic [DW-1:0]       ad_out_q;
    logic                ad_oe_q, ad_q, cs_q, wr_q, rd_q;
    logic [NREG*DW-1:0]  rd_data_q;
    logic                rd_valid_q, burst_done_q, wr_ack_q, busy_q;
    logic [3:0]          rd_idx_q;

    logic                start_edge;
    logic                pend_now;
    logic [DW-1:0]       cur_addr;
    logic [DW-1:0]       addr_tab [16];

    // Entry 0 of ADDR_LIST sits in the MSBs.
    for (genvar g = 0; g < 16; g++) begin : g_tab
        if (g < NREG) begin : g_used
            assign addr_tab[g] = ADDR_LIST[(NREG-1-g)*DW +: DW];
        end else begin : g_unused
            assign addr_tab[g] = '1;
        end
    end

    always_comb begin
        start_edge = start & ~start_q;
        pend_now   = pend_q | start_edge;
        cur_addr   = addr_tab[idx_q];
        if (op_q == OpCmd) begin
            cur_addr = CMD_ADDR;
        end else if (op_q == OpWrite) begin
            cur_addr = waddr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            op_q         <= OpCmd;
            cnt_q        <= '0;
            idx_q        <= '0;
            start_q      <= 1'b0;
            pend_q       <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            ad_out_q     <= '1;
            ad_oe_q      <= 1'b0;
            ad_q         <= 1'b1;
            cs_q         <= 1'b1;
            wr_q         <= 1'b1;
            rd_q         <= 1'b1;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_idx_q     <= '0;
            burst_done_q <= 1'b0;
            wr_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            start_q      <= start;
            rd_valid_q   <= 1'b0;
            burst_done_q <= 1'b0;
            wr_ack_q     <= 1'b0;
            if (start_edge && state_q != StIdle) begin
                pend_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (wr_req) begin
                        op_q    <= OpWrite;
                        waddr_q <= wr_addr;
                        wdata_q <= wr_data;
                        pend_q  <= pend_now;
                        state_q <= StAd;
                        ad_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (pend_now) begin
                        op_q    <= CMD_EN ? OpCmd : OpRead;
                        idx_q   <= '0;
                        pend_q  <= 1'b0;
                        state_q <= StAd;
                        ad_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StAd: begin
                    state_q <= StCsa;
                    cs_q    <= 1'b0;
                end
                StCsa: begin
                    state_q  <= StWra;
                    cnt_q    <= CW'(T_STB - 1);
                    wr_q     <= 1'b0;
                    ad_oe_q  <= 1'b1;
                    ad_out_q <= cur_addr;
                end
                StWra: begin
                    if (cnt_q == '0) begin
                        state_q <= StHa;
                        wr_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StHa: begin
                    state_q <= StCsah;
                    cs_q    <= 1'b1;
                end
                StCsah: begin
                    state_q  <= StAdh;
                    ad_q     <= 1'b1;
                    ad_oe_q  <= 1'b0;
                    ad_out_q <= '1;
                end
                StAdh: begin
                    if (op_q == OpCmd) begin
                        state_q <= StGap;
                        cnt_q   <= CW'(T_GAP - 1);
                    end else begin
                        state_q <= StTurn;
                        cnt_q   <= CW'(T_TURN - 1);
                    end
                end
                StTurn: begin
                    if (cnt_q == '0) begin
                        state_q <= StCsd;
                        cs_q    <= 1'b0;
                        if (op_q == OpWrite) begin
                            ad_oe_q  <= 1'b1;
                            ad_out_q <= wdata_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StCsd: begin
                    state_q <= StStb;
                    cnt_q   <= CW'(T_STB - 1);
                    if (op_q == OpWrite) begin
                        wr_q <= 1'b0;
                    end else begin
                        rd_q <= 1'b0;
                    end
                end
                StStb: begin
                    if (cnt_q == '0) begin
                        state_q <= StHd;
                        wr_q    <= 1'b1;
                        rd_q    <= 1'b1;
                        if (op_q == OpRead) begin
                            for (int i = 0; i < NREG; i++) begin
                                if (idx_q == 4'(i)) begin
                                    rd_data_q[(NREG-1-i)*DW +: DW] <= ad_in;
                                end
                            end
                            rd_valid_q <= 1'b1;
                            rd_idx_q   <= idx_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StHd: begin
                    state_q  <= StCsdh;
                    cs_q     <= 1'b1;
                    ad_oe_q  <= 1'b0;
                    ad_out_q <= '1;
                end
                StCsdh: begin
                    // Data transactions keep one extra idle clock in the gap, giving
                    // 9+2*T_STB+T_TURN+T_GAP clocks per read/write.
                    state_q <= StGap;
                    cnt_q   <= CW'(T_GAP);
                end
                StGap: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (op_q == OpCmd) begin
                        op_q    <= OpRead;
                        idx_q   <= '0;
                        state_q <= StAd;
                        ad_q    <= 1'b0;
                    end else if (op_q == OpRead && idx_q != LAST_IDX) begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= StAd;
                        ad_q    <= 1'b0;
                    end else begin
                        state_q      <= StIdle;
                        busy_q       <= 1'b0;
                        burst_done_q <= (op_q == OpRead);
                        wr_ack_q     <= (op_q == OpWrite);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ad_out     = ad_out_q;
    assign ad_oe      = ad_oe_q;
    assign ad         = ad_q;
    assign cs         = cs_q;
    assign wr         = wr_q;
    assign rd         = rd_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_idx     = rd_idx_q;
    assign burst_done = burst_done_q;
    assign wr_ack     = wr_ack_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rtc_bus_seq.sv
// Directed bench for rtc_bus_seq: default instance plus a short-timing variant,
// each talking to a small RTC model that returns (latched address XOR 8'h5A).
`timescale 1ns/1ps
module tb_rtc_bus_seq;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, start, wr_req;
    logic [7:0]  wr_addr, wr_data, ad_in, ad_out;
    logic        ad_oe, ad, cs, wr, rd, rd_valid, burst_done, wr_ack, busy;
    logic [79:0] rd_data;
    logic [3:0]  rd_idx;

    logic        start3;
    logic        wr_req3  = 1'b0;
    logic [7:0]  wr_addr3 = 8'h00;
    logic [7:0]  wr_data3 = 8'h00;
    logic [7:0]  ad_in3, ad_out3;
    logic        ad_oe3, ad3, cs3, wr3, rd3, rd_valid3, burst_done3, wr_ack3, busy3;
    logic [23:0] rd_data3;
    logic [3:0]  rd_idx3;

    rtc_bus_seq dut (
        .clock(clock), .reset(reset), .start(start), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .ad_in(ad_in), .ad_out(ad_out),
        .ad_oe(ad_oe), .ad(ad), .cs(cs), .wr(wr), .rd(rd), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_idx(rd_idx), .burst_done(burst_done),
        .wr_ack(wr_ack), .busy(busy)
    );

    rtc_bus_seq #(
        .NREG(3), .ADDR_LIST(24'h112233), .CMD_EN(1'b0),
        .T_STB(2), .T_TURN(1), .T_GAP(1)
    ) dut3 (
        .clock(clock), .reset(reset), .start(start3), .wr_req(wr_req3),
        .wr_addr(wr_addr3), .wr_data(wr_data3), .ad_in(ad_in3), .ad_out(ad_out3),
        .ad_oe(ad_oe3), .ad(ad3), .cs(cs3), .wr(wr3), .rd(rd3), .rd_data(rd_data3),
        .rd_valid(rd_valid3), .rd_idx(rd_idx3), .burst_done(burst_done3),
        .wr_ack(wr_ack3), .busy(busy3)
    );

    // RTC models: latch the address driven during the address-phase write strobe.
    logic [7:0] rtc_addr, rtc_addr3;
    always @(posedge clock) begin
        if (!ad && !cs && !wr && ad_oe) rtc_addr <= ad_out;
        if (!ad3 && !cs3 && !wr3 && ad_oe3) rtc_addr3 <= ad_out3;
    end
    assign ad_in  = rtc_addr ^ 8'h5A;
    assign ad_in3 = rtc_addr3 ^ 8'h5A;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus monitor for the default instance: one record per cs-low window.
    logic [9:0] win_q[$];
    int         vidx_q[$];
    int         bd_cnt = 0, ack_cnt = 0, rd_low_total = 0;
    bit         in_win = 0, addr_ph, is_rd, ad_break, prev_wr = 1, prev_rd = 1;
    int         npulse, slen;
    logic [7:0] wval;
    int         v3_cnt = 0;
    bit         got_first3 = 0;
    logic [7:0] first_addr3;

    always @(negedge clock) begin
        if (!reset) begin
            in_win = 0;
        end else begin
            if (!cs) begin
                if (!in_win) begin
                    in_win = 1; addr_ph = !ad; is_rd = 0; ad_break = 0;
                    npulse = 0; slen = 0; wval = 8'h00;
                end
                if (addr_ph && ad) ad_break = 1;
                if (!wr) begin
                    if (prev_wr) npulse++;
                    slen++;
                    wval = ad_out;
                end
                if (!rd) begin
                    if (prev_rd) npulse++;
                    slen++;
                    is_rd = 1;
                    wval = ad_in;
                    check("ad_oe during rd low", 128'(ad_oe), 128'(0));
                end
            end else if (in_win) begin
                in_win = 0;
                check("strobe pulses per cs window", 128'(npulse), 128'(1));
                check("strobe width", 128'(slen), 128'(5));
                check("ad low across address window", 128'(ad_break), 128'(0));
                win_q.push_back({addr_ph, is_rd, wval});
            end
            if (!rd) rd_low_total++;
            prev_wr = wr;
            prev_rd = rd;
            if (rd_valid) vidx_q.push_back(int'(rd_idx));
            if (burst_done) bd_cnt++;
            if (wr_ack) ack_cnt++;
            if (rd_valid3) v3_cnt++;
            if (!wr3 && ad_oe3 && !got_first3) begin
                got_first3 = 1;
                first_addr3 = ad_out3;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, " ad"}, 128'(ad), 128'(1));
        check({tag, " cs"}, 128'(cs), 128'(1));
        check({tag, " wr"}, 128'(wr), 128'(1));
        check({tag, " rd"}, 128'(rd), 128'(1));
        check({tag, " ad_oe"}, 128'(ad_oe), 128'(0));
        check({tag, " ad_out"}, 128'(ad_out), 128'(8'hFF));
        check({tag, " busy"}, 128'(busy), 128'(0));
        check({tag, " rd_data"}, 128'(rd_data), 128'(0));
        check({tag, " rd_valid"}, 128'(rd_valid), 128'(0));
        check({tag, " burst_done"}, 128'(burst_done), 128'(0));
        check({tag, " wr_ack"}, 128'(wr_ack), 128'(0));
        check({tag, " rd_idx"}, 128'(rd_idx), 128'(0));
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wvec_t;

    // ctl = {ad, cs, wr, rd, ad_oe, busy, wr_ack}; sel: 0 = FF, 1 = address, 2 = data
    typedef struct {
        int         offs;
        logic [6:0] ctl;
        int         sel;
    } cp_t;

    logic [7:0] exp_addr [10];
    wvec_t      wvecs [2];
    cp_t        cps [18];

    initial begin
        int t, t_ad, bd0, ack0, rl;
        logic [9:0] ew;
        logic [7:0] eo;

        exp_addr = '{8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41, 8'h01};
        wvecs = '{'{8'h24, 8'h12}, '{8'h3C, 8'hA5}};
        cps = '{
            '{0,  7'b0111010, 0}, '{1,  7'b0011010, 0}, '{2,  7'b0001110, 1},
            '{6,  7'b0001110, 1}, '{7,  7'b0011110, 1}, '{8,  7'b0111110, 1},
            '{9,  7'b1111010, 0}, '{10, 7'b1111010, 0}, '{17, 7'b1111010, 0},
            '{18, 7'b1011110, 2}, '{19, 7'b1001110, 2}, '{23, 7'b1001110, 2},
            '{24, 7'b1011110, 2}, '{25, 7'b1111010, 0}, '{26, 7'b1111010, 0},
            '{36, 7'b1111010, 0}, '{37, 7'b1111001, 0}, '{38, 7'b1111000, 0}
        };

        reset = 1'b0; start = 1'b0; start3 = 1'b0; wr_req = 1'b0;
        wr_addr = 8'h00; wr_data = 8'h00;
        repeat (3) @(negedge clock);
        check_reset_state("reset");
        reset = 1'b1;
        @(negedge clock);
        check("idle after reset busy", 128'(busy), 128'(0));

        // Default burst: command cycle then 10 reads.
        win_q.delete(); vidx_q.delete();
        start = 1'b1;
        @(negedge clock);
        check("ad low one clock after start edge", 128'(ad), 128'(0));
        t_ad = cyc;
        while (!burst_done && cyc < t_ad + 1000) @(negedge clock);
        check("burst_done seen", 128'(burst_done), 128'(1));
        check("burst length", 128'(cyc - t_ad), 128'(390));
        @(negedge clock);
        #1;
        check("burst_done pulse width", 128'(burst_done), 128'(0));
        check("busy after burst", 128'(busy), 128'(0));
        check("burst window count", 128'(win_q.size()), 128'(21));
        for (int j = 0; j < 21 && j < win_q.size(); j++) begin
            if (j == 0) ew = {1'b1, 1'b0, 8'hF0};
            else if ((j - 1) % 2 == 0) ew = {1'b1, 1'b0, exp_addr[(j-1)/2]};
            else ew = {1'b0, 1'b1, exp_addr[(j-1)/2] ^ 8'h5A};
            check($sformatf("burst window %0d", j), 128'(win_q[j]), 128'(ew));
        end
        check("rd_valid count", 128'(vidx_q.size()), 128'(10));
        for (int i = 0; i < 10 && i < vidx_q.size(); i++)
            check($sformatf("rd_idx order %0d", i), 128'(vidx_q[i]), 128'(i));
        for (int i = 0; i < 10; i++)
            check($sformatf("rd_data entry %0d", i), 128'(rd_data[(9-i)*8 +: 8]),
                  128'(exp_addr[i] ^ 8'h5A));
        check("rd_data entry 0 value", 128'(rd_data[79:72]), 128'(8'h7C));
        check("rd_data entry 9 value", 128'(rd_data[7:0]), 128'(8'h5B));
        start = 1'b0;
        repeat (3) @(negedge clock);

        // Single writes, checked against a cycle-by-cycle checkpoint table.
        for (int w = 0; w < 2; w++) begin
            #1;
            win_q.delete(); rl = rd_low_total; ack0 = ack_cnt;
            wr_addr = wvecs[w].addr; wr_data = wvecs[w].data; wr_req = 1'b1;
            t = cyc;
            for (int c = 0; c < 18; c++) begin
                while (cyc < t + 1 + cps[c].offs) @(negedge clock);
                eo = (cps[c].sel == 1) ? wvecs[w].addr :
                     (cps[c].sel == 2) ? wvecs[w].data : 8'hFF;
                check($sformatf("write %0d ctl k%0d", w, cps[c].offs),
                      128'({ad, cs, wr, rd, ad_oe, busy, wr_ack}), 128'(cps[c].ctl));
                check($sformatf("write %0d ad_out k%0d", w, cps[c].offs), 128'(ad_out), 128'(eo));
                if (c == 0) begin
                    wr_addr = 8'hFF; wr_data = 8'h00;
                end
                if (wr_ack) wr_req = 1'b0;
            end
            wr_req = 1'b0;
            #1;
            check("rd never low during write", 128'(rd_low_total - rl), 128'(0));
            check("write window count", 128'(win_q.size()), 128'(2));
            if (win_q.size() == 2) begin
                check("write address window", 128'(win_q[0]), 128'({2'b10, wvecs[w].addr}));
                check("write data window", 128'(win_q[1]), 128'({2'b00, wvecs[w].data}));
            end
            check("single wr_ack", 128'(ack_cnt - ack0), 128'(1));
        end

        // Collision: write wins, pending burst follows; second edge adds one burst.
        @(negedge clock);
        #1;
        win_q.delete(); bd0 = bd_cnt;
        wr_addr = 8'h10; wr_data = 8'h99; wr_req = 1'b1; start = 1'b1;
        t = cyc;
        @(negedge clock);
        while (!wr_ack && cyc < t + 100) @(negedge clock);
        check("collision wr_ack", 128'(wr_ack), 128'(1));
        check("no burst before wr_ack", 128'(bd_cnt - bd0), 128'(0));
        wr_req = 1'b0;
        @(negedge clock);
        check("burst starts after wr_ack", 128'({busy, ad}), 128'(2'b10));
        #1;
        if (win_q.size() >= 2) begin
            check("collision write address", 128'(win_q[0]), 128'({2'b10, 8'h10}));
            check("collision write data", 128'(win_q[1]), 128'({2'b00, 8'h99}));
        end else begin
            check("collision window count", 128'(win_q.size()), 128'(2));
        end
        repeat (100) @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        t = cyc;
        while ((bd_cnt - bd0) < 2 && cyc < t + 2000) @(negedge clock);
        repeat (500) @(negedge clock);
        #1;
        check("bursts after collision", 128'(bd_cnt - bd0), 128'(2));
        check("idle after collision", 128'(busy), 128'(0));
        start = 1'b0;

        // Reset in the middle of a burst.
        @(negedge clock);
        start = 1'b1;
        repeat (100) @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_state("mid-burst reset");
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("no restart after reset", 128'(busy), 128'(0));
        check("rd_data stays cleared", 128'(rd_data), 128'(0));

        // Short-timing variant without command cycle.
        #1;
        v3_cnt = 0; got_first3 = 0;
        start3 = 1'b1;
        @(negedge clock);
        check("variant ad low after start", 128'(ad3), 128'(0));
        t_ad = cyc;
        while (!burst_done3 && cyc < t_ad + 200) @(negedge clock);
        check("variant burst_done seen", 128'(burst_done3), 128'(1));
        check("variant burst length", 128'(cyc - t_ad), 128'(45));
        @(negedge clock);
        #1;
        check("variant rd_data", 128'(rd_data3), 128'(24'h4B7869));
        check("variant first address (no command)", 128'(first_addr3), 128'(8'h11));
        check("variant rd_valid count", 128'(v3_cnt), 128'(3));
        start3 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
